// File: rtl/prop_monitor.sv
// Bounded-window checker for property flags: sticky hit bits, first-hit index/cycle,
// and busy/done status for a fixed-length (or stop-on-first-hit) sampling window.
module prop_monitor #(
    parameter int NUM_PROPS   = 4,
    parameter int CNT_W       = 8,
    parameter int BOUND       = 20,
    parameter bit STOP_ON_HIT = 1'b0,
    parameter int IDX_W       = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_PROPS-1:0] prop_in,
    output logic                 busy,
    output logic                 done,
    output logic                 any_hit,
    output logic [NUM_PROPS-1:0] hit_sticky,
    output logic [IDX_W-1:0]     first_hit_idx,
    output logic [CNT_W-1:0]     first_hit_cyc,
    output logic [CNT_W-1:0]     cycle_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 any_hit_q, any_hit_d;
    logic [NUM_PROPS-1:0] hit_sticky_q, hit_sticky_d;
    logic [IDX_W-1:0]     first_hit_idx_q, first_hit_idx_d;
    logic [CNT_W-1:0]     first_hit_cyc_q, first_hit_cyc_d;
    logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d;

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_PROPS-1:0] v);
        logic [IDX_W-1:0] idx;
        logic             found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < int'(NUM_PROPS); i++) begin
            if (v[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    always_comb begin
        state_d         = state_q;
        hit_sticky_d    = hit_sticky_q;
        first_hit_idx_d = first_hit_idx_q;
        first_hit_cyc_d = first_hit_cyc_q;
        cycle_cnt_d     = cycle_cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d         = RUN;
                    hit_sticky_d    = '0;
                    first_hit_idx_d = '0;
                    first_hit_cyc_d = '0;
                    cycle_cnt_d     = '0;
                end
            end
            RUN: begin
                hit_sticky_d = hit_sticky_q | prop_in;
                if ((hit_sticky_q == '0) && (prop_in != '0)) begin
                    first_hit_idx_d = lowest_idx(prop_in);
                    first_hit_cyc_d = cycle_cnt_q;
                end
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
                if ((cycle_cnt_q == CNT_W'(BOUND - 1)) || (STOP_ON_HIT && (|prop_in)))
                    state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        // Status flags follow the next state so they line up with the registered results.
        busy_d    = (state_d == RUN);
        done_d    = (state_d == DONE);
        any_hit_d = |hit_sticky_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            any_hit_q       <= 1'b0;
            hit_sticky_q    <= '0;
            first_hit_idx_q <= '0;
            first_hit_cyc_q <= '0;
            cycle_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            any_hit_q       <= any_hit_d;
            hit_sticky_q    <= hit_sticky_d;
            first_hit_idx_q <= first_hit_idx_d;
            first_hit_cyc_q <= first_hit_cyc_d;
            cycle_cnt_q     <= cycle_cnt_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign any_hit       = any_hit_q;
    assign hit_sticky    = hit_sticky_q;
    assign first_hit_idx = first_hit_idx_q;
    assign first_hit_cyc = first_hit_cyc_q;
    assign cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_prop_monitor.sv
// Bench for prop_monitor: one full-window instance and one stop-on-hit instance,
// driven from a vector table through an expected-result queue.
module tb_prop_monitor;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       any_hit;
        logic [3:0] hit;
        logic [1:0] idx;
        logic [7:0] cyc;
        logic [7:0] cnt;
    } out_t;

    typedef struct {
        string      tag;
        bit         sel;
        bit         start;
        logic [3:0] prop;
        out_t       exp;
    } vec_t;

    logic       clk, reset;
    logic       start_a, start_b;
    logic [3:0] prop_a, prop_b;

    logic       a_busy, a_done, a_any;
    logic [3:0] a_hit;
    logic [1:0] a_idx;
    logic [7:0] a_cyc, a_cnt;
    logic       b_busy, b_done, b_any;
    logic [3:0] b_hit;
    logic [1:0] b_idx;
    logic [7:0] b_cyc, b_cnt;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];
    out_t sb[$];

    prop_monitor #(.NUM_PROPS(4), .CNT_W(8), .BOUND(20), .STOP_ON_HIT(1'b0), .IDX_W(2)) dut_a (
        .clk(clk), .reset(reset), .start(start_a), .prop_in(prop_a),
        .busy(a_busy), .done(a_done), .any_hit(a_any), .hit_sticky(a_hit),
        .first_hit_idx(a_idx), .first_hit_cyc(a_cyc), .cycle_cnt(a_cnt)
    );

    prop_monitor #(.NUM_PROPS(4), .CNT_W(8), .BOUND(20), .STOP_ON_HIT(1'b1), .IDX_W(2)) dut_b (
        .clk(clk), .reset(reset), .start(start_b), .prop_in(prop_b),
        .busy(b_busy), .done(b_done), .any_hit(b_any), .hit_sticky(b_hit),
        .first_hit_idx(b_idx), .first_hit_cyc(b_cyc), .cycle_cnt(b_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    function automatic out_t mk(bit bz, bit dn, logic [3:0] hit, logic [1:0] idx,
                                logic [7:0] cyc, logic [7:0] cnt);
        out_t o;
        o.busy    = bz;
        o.done    = dn;
        o.any_hit = (hit != 4'b0000);
        o.hit     = hit;
        o.idx     = idx;
        o.cyc     = cyc;
        o.cnt     = cnt;
        return o;
    endfunction

    function automatic void add(string tag, bit sel, bit st, logic [3:0] pr, out_t e);
        vec_t v;
        v.tag   = tag;
        v.sel   = sel;
        v.start = st;
        v.prop  = pr;
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    function automatic out_t got_of(bit sel);
        out_t o;
        if (sel) o = '{b_busy, b_done, b_any, b_hit, b_idx, b_cyc, b_cnt};
        else     o = '{a_busy, a_done, a_any, a_hit, a_idx, a_cyc, a_cnt};
        return o;
    endfunction

    task automatic compare(input string tag, input out_t got, input out_t e);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got busy=%0b done=%0b any=%0b hit=%b idx=%0d cyc=%0d cnt=%0d, exp busy=%0b done=%0b any=%0b hit=%b idx=%0d cyc=%0d cnt=%0d",
                     tag, got.busy, got.done, got.any_hit, got.hit, got.idx, got.cyc, got.cnt,
                     e.busy, e.done, e.any_hit, e.hit, e.idx, e.cyc, e.cnt);
        end
    endtask

    task automatic apply(input vec_t v);
        out_t e;
        @(negedge clk);
        start_a = v.sel ? 1'b0 : v.start;
        prop_a  = v.sel ? 4'b0000 : v.prop;
        start_b = v.sel ? v.start : 1'b0;
        prop_b  = v.sel ? v.prop : 4'b0000;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        compare(v.tag, got_of(v.sel), e);
    endtask

    initial begin
        logic [7:0] x, y, xn;
        logic [3:0] pr;
        out_t zero;
        vec_t v;
        zero = mk(0, 0, 4'b0000, 2'd0, 8'd0, 8'd0);

        // Idle with flags asserted and no start: nothing moves.
        for (int k = 0; k < 10; k++) add("idle_ignore", 0, 0, 4'hF, zero);

        // Full window, no hits.
        add("clean_start", 0, 1, 4'h0, mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0));
        for (int k = 0; k < 20; k++)
            add("clean_win", 0, 0, 4'h0, mk(k < 19, k == 19, 4'b0000, 2'd0, 8'd0, 8'(k + 1)));
        add("clean_hold", 0, 0, 4'hF, mk(0, 1, 4'b0000, 2'd0, 8'd0, 8'd20));

        // Multi-bit first hit at k=5, later hit at k=7; flags deassert afterwards.
        add("hits_start", 0, 1, 4'hF, mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0));
        for (int k = 0; k < 20; k++) begin
            pr = (k == 5) ? 4'b1010 : (k == 7) ? 4'b0001 : 4'b0000;
            add("hits_win", 0, 0, pr,
                mk(k < 19, k == 19,
                   (k >= 7) ? 4'b1011 : (k >= 5) ? 4'b1010 : 4'b0000,
                   (k >= 5) ? 2'd1 : 2'd0, (k >= 5) ? 8'd5 : 8'd0, 8'(k + 1)));
        end
        add("hits_hold", 0, 0, 4'hF, mk(0, 1, 4'b1011, 2'd1, 8'd5, 8'd20));

        // Flags derived from a Fibonacci accumulator; start pulsed mid-run is ignored.
        add("acc_start", 0, 1, 4'h0, mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0));
        x = 8'd1;
        y = 8'd1;
        for (int k = 0; k < 20; k++) begin
            pr = {(x == 8'd0), (y > x), (x > 8'd200), (y == 8'd0)};
            add("acc_win", 0, k == 10, pr,
                mk(k < 19, k == 19, 4'b0000, 2'd0, 8'd0, 8'(k + 1)));
            if (x < 8'd144) begin
                xn = x + y;
                y  = x;
                x  = xn;
            end else begin
                y = x;
            end
        end

        // Stop-on-hit instance: hit at k=3 ends the window with cycle_cnt=4.
        add("stop_start", 1, 1, 4'h0, mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0));
        for (int k = 0; k < 4; k++) begin
            pr = (k == 3) ? 4'b0100 : 4'b0000;
            add("stop_win", 1, 0, pr,
                mk(k < 3, k == 3, (k == 3) ? 4'b0100 : 4'b0000,
                   (k == 3) ? 2'd2 : 2'd0, (k == 3) ? 8'd3 : 8'd0, 8'(k + 1)));
        end
        add("stop_hold", 1, 0, 4'hF, mk(0, 1, 4'b0100, 2'd2, 8'd3, 8'd4));
        // Restart from DONE: flags on the start edge are not sampled; hit at k=0.
        add("stop_restart", 1, 1, 4'b0001, mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0));
        add("stop_k0", 1, 0, 4'b0011, mk(0, 1, 4'b0011, 2'd0, 8'd0, 8'd1));

        start_a = 1'b0;
        start_b = 1'b0;
        prop_a  = 4'h0;
        prop_b  = 4'h0;
        reset   = 1'b1;
        #2;
        compare("reset_a", got_of(0), zero);
        compare("reset_b", got_of(1), zero);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

        // Asynchronous reset mid-window at k=9 with hits recorded.
        v.sel = 0; v.start = 1; v.prop = 4'h0; v.tag = "rst_start";
        v.exp = mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0);
        apply(v);
        for (int k = 0; k < 9; k++) begin
            v.start = 0;
            v.prop  = (k == 2) ? 4'b0010 : 4'b0000;
            v.tag   = "rst_win";
            v.exp   = mk(1, 0, (k >= 2) ? 4'b0010 : 4'b0000, (k >= 2) ? 2'd1 : 2'd0,
                         (k >= 2) ? 8'd2 : 8'd0, 8'(k + 1));
            apply(v);
        end
        @(negedge clk);
        prop_a = 4'b0001;
        #2;
        reset = 1'b1;
        #1;
        compare("async_reset_a", got_of(0), zero);
        compare("async_reset_b", got_of(1), zero);
        @(negedge clk);
        reset = 1'b0;
        v.start = 0; v.prop = 4'hF; v.tag = "post_reset_idle"; v.exp = zero;
        apply(v);
        v.start = 1; v.prop = 4'h0; v.tag = "post_reset_start";
        v.exp = mk(1, 0, 4'b0000, 2'd0, 8'd0, 8'd0);
        apply(v);
        v.start = 0; v.prop = 4'b1000; v.tag = "post_reset_k0";
        v.exp = mk(1, 0, 4'b1000, 2'd3, 8'd0, 8'd1);
        apply(v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
